// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built from one full-adder cell
// and a carry flip-flop. One bit is processed per clock, LSB first.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous reset, active high, overrides everything
//   start  - request a new operation (accepted only in IDLE or DONE)
//   a, b   - operands, captured on an accepted start
//   cin    - carry-in (borrow-in when subtracting), captured on start
//   sub    - (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b - cin
//   busy   - high while the operation is in progress
//   done   - one-cycle pulse, sum/cout valid
//   sum    - result, stable from done until the next accepted start
//   cout   - final carry-out (borrow-out when subtracting)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port.

module serial_adder_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic           carry;
    logic [CW-1:0]  cnt;
    logic           fa_s, fa_co;
    logic           accept;
    logic           last;
    logic           sub_q;

    // Subtraction is a + ~b + ~borrow_in; sub_q remembers to invert the
    // final carry so cout reads as borrow-out.
`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk) begin
        if (rst)
            sub_q <= 1'b0;
        else if (accept)
            sub_q <= sub;
    end
    logic sub_in;
    assign sub_in = sub;
`else
    logic sub_in;
    assign sub_q  = 1'b0;
    assign sub_in = 1'b0;
`endif

    serial_adder_fa u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b ^ {WIDTH{sub_in}};
            carry <= cin ^ sub_in;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            // New bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
            sum   <= {fa_s, sum[WIDTH-1:1]};
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= fa_co;
            if (last)
                cout <= fa_co ^ sub_q;
            else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub;
`endif
  logic       busy, done, cout;
  logic [7:0] sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_expired(input string tag, input int lat);
    checks++;
    if (!done) begin
      errors++;
      $error("FAIL %s: done not seen within %0d cycles", tag, lat);
    end
  endtask

  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb,
                        input logic c, output int lat, output int bcnt);
    a = aa; b = bb; cin = c; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      step();
      lat++;
    end
    wait_expired("run_op_wait", lat);
  endtask

  initial begin
    int lat, bcnt, pulses;
    logic [7:0] hs;
    logic       hc;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      errors++;
      $error("FAIL reset_state: busy=%b done=%b sum=%0h cout=%b", busy, done, sum, cout);
    end
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum",  sum,  8'h00);
    chk("rst_cout", cout, 1'b0);
    rst = 1'b0;

    a = 8'h3C; b = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_sum",  sum,  8'h00);
    chk("abort_cout", cout, 1'b0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    run_op(8'h3C, 8'h5A, 1'b0, lat, bcnt);
    chk("add_lat",  lat,  9);
    chk("add_busy", bcnt, 8);
    chk("add_sum",  sum,  8'h96);
    chk("add_cout", cout, 1'b0);
    step();
    chk("done_pulse_one_cycle", done, 1'b0);

    run_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
    chk("ff01_done", done, 1'b1);
    chk("ff01_sum",  sum,  8'h00);
    chk("ff01_cout", cout, 1'b1);
    step();
    run_op(8'hFF, 8'hFF, 1'b1, lat, bcnt);
    chk("ffff_done", done, 1'b1);
    chk("ffff_sum",  sum,  8'hFF);
    chk("ffff_cout", cout, 1'b1);
    step();

    a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
    step();
    a = 8'h11; b = 8'h22; cin = 1'b1;
    lat = 1;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    wait_expired("hold_start_wait", lat);
    chk("hold_start_lat",  lat,  9);
    chk("hold_start_sum",  sum,  8'h96);
    chk("hold_start_cout", cout, 1'b0);
    a = 8'h01; b = 8'h02; cin = 1'b0;
    step();
    start = 1'b0;
    chk("b2b_busy", busy, 1'b1);
    chk("b2b_done", done, 1'b0);
    lat = 1;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    wait_expired("b2b_wait", lat);
    chk("b2b_lat",  lat,  9);
    chk("b2b_sum",  sum,  8'h03);
    chk("b2b_cout", cout, 1'b0);

    hs = sum; hc = cout;
    chk("hold_ref_sum", hs, 8'h03);
    chk("hold_ref_cout", hc, 1'b0);
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      step();
      chk("hold_sum",  sum,  8'h03);
      chk("hold_cout", cout, 1'b0);
      chk("hold_done", done, 1'b0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op(8'h10, 8'h01, 1'b0, lat, bcnt);
    sub = 1'b0;
    chk("sub1_sum",  sum,  8'h0F);
    chk("sub1_cout", cout, 1'b0);
    step();
    sub = 1'b1;
    run_op(8'h00, 8'h01, 1'b0, lat, bcnt);
    sub = 1'b0;
    chk("sub2_sum",  sum,  8'hFF);
    chk("sub2_cout", cout, 1'b1);
    step();
    sub = 1'b1;
    run_op(8'h05, 8'h05, 1'b1, lat, bcnt);
    sub = 1'b0;
    chk("sub3_sum",  sum,  8'hFF);
    chk("sub3_cout", cout, 1'b1);
    step();
    run_op(8'h10, 8'h01, 1'b0, lat, bcnt);
    chk("sub0_add_sum",  sum,  8'h11);
    chk("sub0_add_cout", cout, 1'b0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
